// File: rtl/terrain_engine.sv
// terrain_engine: column height-map generator with optional crater carving.
// Heights are measured from the top of the screen (larger = lower ground).
// A random-walk generator fills NCOLS columns after reset or on start_gen.
// Optional feature macro: TERRAIN_CARVE_EN (adds the crater carve states).
module terrain_engine #(
  parameter  int NCOLS     = 640,
  parameter  int NROWS     = 480,
  parameter  int DEFAULT_H = 310,
  parameter  int MIN_H     = 64,
  localparam int XW        = $clog2(NCOLS),
  localparam int YW        = $clog2(NROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   seed,
  input  logic [1:0]    mode,
  input  logic          start_gen,
  input  logic [XW-1:0] rd_col,
  input  logic [YW-1:0] draw_y,
  output logic [YW-1:0] rd_height,
  output logic          draw_terrain,
  input  logic          carve_req,
  input  logic [XW-1:0] carve_x,
  input  logic [YW-1:0] carve_y,
  input  logic [5:0]    carve_r,
  output logic          carve_ack,
  output logic          busy,
  output logic          gen_done
);

  // Height accumulator carries two extra bits so the sum never wraps before clamping.
  localparam int HW = YW + 2;

  localparam logic signed [HW-1:0] H_MIN    = HW'(MIN_H);
  localparam logic signed [HW-1:0] H_MAX    = HW'(NROWS - 1);
  localparam logic signed [HW-1:0] H_DEF    = HW'(DEFAULT_H);
  localparam logic [XW-1:0]        LAST_COL = XW'(NCOLS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_GEN      = 2'd1;
`ifdef TERRAIN_CARVE_EN
  localparam logic [1:0] S_CARVE_RD = 2'd2;
  localparam logic [1:0] S_CARVE_WR = 2'd3;
`endif

  logic [YW-1:0]        mem [NCOLS];
  logic [1:0]           state_reg;
  logic [XW-1:0]        col_reg;
  logic signed [9:0]    noise_reg;
  logic signed [HW-1:0] h_reg;
  logic [15:0]          lfsr_reg;
  logic                 init_reg;
  logic                 gen_done_reg;
  logic [YW-1:0]        rd_height_reg;

  logic [15:0]          seed_fix;
  logic [15:0]          lfsr_cur;
  logic [15:0]          lfsr_adv;
  logic [9:0]           rng;
  logic signed [9:0]    bias;
  logic signed [9:0]    noise_fb;
  logic signed [9:0]    noise_next;
  logic signed [9:0]    noise_shr;
  logic signed [HW-1:0] h_delta;
  logic signed [HW-1:0] h_next;
  logic signed [HW-1:0] h_wr;
  logic [YW-1:0]        gen_data;

  logic                 wr_en;
  logic [XW-1:0]        wr_addr;
  logic [YW-1:0]        wr_data;

  function automatic logic signed [HW-1:0] clamp_h(input logic signed [HW-1:0] v);
    if (v < H_MIN)
      return H_MIN;
    else if (v > H_MAX)
      return H_MAX;
    else
      return v;
  endfunction

  // On the first GEN cycle the LFSR value comes straight from the seed, so
  // reset and GEN entry both restart the sequence without an async data load.
  always_comb begin
    seed_fix = (seed == 16'h0000) ? 16'hACE1 : seed;
    lfsr_cur = init_reg ? seed_fix : lfsr_reg;
    lfsr_adv = {lfsr_cur[14:0], lfsr_cur[15] ^ lfsr_cur[13] ^ lfsr_cur[12] ^ lfsr_cur[10]};
    rng      = lfsr_cur[9:0];
  end

  // Noise filter and height step; mode[1] selects rugged constants.
  always_comb begin
    bias       = mode[1] ? 10'sd58 : 10'sd53;
    noise_fb   = (noise_reg >>> 1) + (noise_reg >>> 2) + (noise_reg >>> 3)
               + $signed({3'b000, rng[9:3]}) - bias;
    noise_next = (mode == 2'b00) ? 10'sd0 : noise_fb;
    noise_shr  = mode[1] ? (noise_reg >>> 6) : (noise_reg >>> 7);
    h_delta    = {{(HW-10){noise_shr[9]}}, noise_shr};
    h_next     = clamp_h(h_reg + h_delta);
    h_wr       = clamp_h(h_reg);
    gen_data   = h_wr[YW-1:0];
  end

`ifdef TERRAIN_CARVE_EN
  localparam int TW = ((XW > YW) ? XW : YW) + 2;
  localparam logic [XW:0]   LAST_EXT = (XW+1)'(NCOLS - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(NROWS - 1);

  logic                 carve_ack_reg;
  logic [XW-1:0]        cx_reg;
  logic [YW-1:0]        cy_reg;
  logic [5:0]           r_reg;
  logic [XW-1:0]        x_reg;
  logic [XW-1:0]        x_end_reg;
  logic [YW-1:0]        carve_h_reg;

  logic                 carve_accept;
  logic [XW:0]          cx_ext;
  logic [XW:0]          r_ext;
  logic [XW:0]          lo_ext;
  logic [XW:0]          hi_sum;
  logic [XW-1:0]        x_lo;
  logic [XW-1:0]        x_hi;
  logic [XW-1:0]        dist;
  logic signed [TW-1:0] tgt;
  logic signed [TW-1:0] hold;
  logic signed [TW-1:0] best;
  logic [YW-1:0]        carve_data;

  // Column window of the crater, clipped to the screen edges.
  always_comb begin
    carve_accept = (state_reg == S_IDLE) && !start_gen && carve_req;
    cx_ext       = {1'b0, carve_x};
    r_ext        = (XW+1)'(carve_r);
    lo_ext       = (cx_ext > r_ext) ? (cx_ext - r_ext) : '0;
    x_lo         = (lo_ext > LAST_EXT) ? LAST_COL : lo_ext[XW-1:0];
    hi_sum       = cx_ext + r_ext;
    x_hi         = (hi_sum > LAST_EXT) ? LAST_COL : hi_sum[XW-1:0];
  end

  // New column depth: a V-shaped crater floor that can only push ground down.
  always_comb begin
    dist       = (x_reg >= cx_reg) ? (x_reg - cx_reg) : (cx_reg - x_reg);
    tgt        = $signed(TW'(cy_reg) + TW'(r_reg) - TW'(dist));
    hold       = $signed(TW'(carve_h_reg));
    best       = (tgt > hold) ? tgt : hold;
    carve_data = (best > $signed(TW'(Y_MAX))) ? Y_MAX : best[YW-1:0];
  end

  // Crater parameters, column walk and the registered acknowledge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carve_ack_reg <= 1'b0;
      cx_reg        <= '0;
      cy_reg        <= '0;
      r_reg         <= '0;
      x_reg         <= '0;
      x_end_reg     <= '0;
    end else begin
      carve_ack_reg <= carve_accept;
      if (carve_accept) begin
        cx_reg    <= carve_x;
        cy_reg    <= carve_y;
        r_reg     <= carve_r;
        x_reg     <= x_lo;
        x_end_reg <= x_hi;
      end else if (state_reg == S_CARVE_WR && x_reg != x_end_reg) begin
        x_reg <= x_reg + XW'(1);
      end
    end
  end

  // Second read port dedicated to the carve read-modify-write.
  always_ff @(posedge clk) begin
    carve_h_reg <= mem[x_reg];
  end

  assign carve_ack = carve_ack_reg;
`else
  logic carve_unused;
  assign carve_unused = ^{carve_req, carve_x, carve_y, carve_r};
  assign carve_ack    = 1'b0;
`endif

  // Single write port shared by generation and carving.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = col_reg;
    wr_data = gen_data;
    if (state_reg == S_GEN) begin
      wr_en = 1'b1;
    end
`ifdef TERRAIN_CARVE_EN
    else if (state_reg == S_CARVE_WR) begin
      wr_en   = 1'b1;
      wr_addr = x_reg;
      wr_data = carve_data;
    end
`endif
  end

  // Height array; contents survive reset and are refilled by the automatic GEN.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Registered display read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_height_reg <= '0;
    else
      rd_height_reg <= mem[rd_col];
  end

  // Control FSM and generator state; reset lands directly in GEN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_GEN;
      init_reg     <= 1'b1;
      col_reg      <= '0;
      noise_reg    <= '0;
      h_reg        <= H_DEF;
      lfsr_reg     <= 16'hACE1;
      gen_done_reg <= 1'b0;
    end else begin
      gen_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_gen) begin
            state_reg <= S_GEN;
            init_reg  <= 1'b1;
            col_reg   <= '0;
            noise_reg <= '0;
            h_reg     <= H_DEF;
          end
`ifdef TERRAIN_CARVE_EN
          else if (carve_req) begin
            state_reg <= S_CARVE_RD;
          end
`endif
        end
        S_GEN: begin
          init_reg  <= 1'b0;
          lfsr_reg  <= lfsr_adv;
          noise_reg <= noise_next;
          h_reg     <= h_next;
          if (col_reg == LAST_COL) begin
            col_reg      <= '0;
            state_reg    <= S_IDLE;
            gen_done_reg <= 1'b1;
          end else begin
            col_reg <= col_reg + XW'(1);
          end
        end
`ifdef TERRAIN_CARVE_EN
        S_CARVE_RD: begin
          state_reg <= S_CARVE_WR;
        end
        S_CARVE_WR: begin
          if (x_reg == x_end_reg)
            state_reg <= S_IDLE;
          else
            state_reg <= S_CARVE_RD;
        end
`endif
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_height    = rd_height_reg;
  assign draw_terrain = (draw_y >= rd_height_reg);
  assign busy         = (state_reg != S_IDLE);
  assign gen_done     = gen_done_reg;

endmodule

// File: tb/tb_terrain_engine.sv
// tb_terrain_engine: directed bench for terrain_engine.
// Covers reset-driven generation, readback, drawing, collision, gentle and
// rugged generation, mid-operation reset, and (with TERRAIN_CARVE_EN) craters.
module tb_terrain_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [15:0] seed = 16'hACE1;
  logic [1:0] mode = 2'b00;
  logic       start_gen = 1'b0;
  logic [9:0] rd_col = '0;
  logic [8:0] draw_y = '0;
  logic [8:0] rd_height;
  logic       draw_terrain;
  logic       carve_req = 1'b0;
  logic [9:0] carve_x = '0;
  logic [8:0] carve_y = '0;
  logic [5:0] carve_r = '0;
  logic       carve_ack;
  logic       busy;
  logic       gen_done;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_h [640];

  always #5 clk = ~clk;

  terrain_engine dut (
    .clk(clk), .reset(reset), .seed(seed), .mode(mode), .start_gen(start_gen),
    .rd_col(rd_col), .draw_y(draw_y), .rd_height(rd_height), .draw_terrain(draw_terrain),
    .carve_req(carve_req), .carve_x(carve_x), .carve_y(carve_y), .carve_r(carve_r),
    .carve_ack(carve_ack), .busy(busy), .gen_done(gen_done)
  );

  task automatic read_col(input int c, output logic [8:0] h);
    rd_col = 10'(c);
    @(negedge clk);
    h = rd_height;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start_gen = 1'b1;
    @(negedge clk);
    start_gen = 1'b0;
  endtask

  // Reference generator: LFSR taps 16/14/13/11, 10-bit wrapping noise filter.
  task automatic gen_model(input logic [15:0] sd, input logic [1:0] md);
    logic [15:0] l;
    int n, h, bias, sh, u, t;
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    n = 0;
    h = 310;
    bias = (md == 2'b01) ? 53 : 58;
    sh   = (md == 2'b01) ? 7 : 6;
    for (int c = 0; c < 640; c++) begin
      exp_h[c] = h;
      u = int'(l[9:3]);
      if (md == 2'b00) begin
        t = 0;
      end else begin
        t = (n >>> 1) + (n >>> 2) + (n >>> 3) + u - bias;
        t = ((t % 1024) + 1024) % 1024;
        if (t >= 512) t = t - 1024;
      end
      h = h + (n >>> sh);
      if (h < 64) h = 64;
      if (h > 479) h = 479;
      n = t;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  task automatic test_reset();
    int n;
    mode = 2'b00;
    seed = 16'hACE1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_cmp++; if (gen_done !== 1'b0) begin n_mis++; $display("FAIL reset_gen_done: got %b expected 0", gen_done); end
    n_cmp++; if (carve_ack !== 1'b0) begin n_mis++; $display("FAIL reset_carve_ack: got %b expected 0", carve_ack); end
    n_cmp++; if (rd_height !== 9'd0) begin n_mis++; $display("FAIL reset_rd_height: got %0d expected 0", rd_height); end
    n_cmp++; if (draw_terrain !== 1'b1) begin n_mis++; $display("FAIL reset_draw: got %b expected 1", draw_terrain); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_idle(n);
    n_cmp++; if (n != 640) begin n_mis++; $display("FAIL reset_gen_cycles: got %0d expected 640", n); end
    n_cmp++; if (gen_done !== 1'b1) begin n_mis++; $display("FAIL reset_gen_done_pulse: got %b expected 1", gen_done); end
    @(negedge clk);
    n_cmp++; if (gen_done !== 1'b0) begin n_mis++; $display("FAIL gen_done_width: got %b expected 0", gen_done); end
    $display("test_reset: busy for %0d cycles after release", n);
  endtask

  task automatic test_flat_readback();
    logic [8:0] h;
    for (int c = 0; c < 640; c++) begin
      read_col(c, h);
      n_cmp++;
      if (h !== 9'd310) begin n_mis++; $display("FAIL flat_col%0d: got %0d expected 310", c, h); end
    end
    $display("test_flat_readback: 640 columns read");
  endtask

  task automatic test_draw();
    rd_col = 10'd5;
    draw_y = 9'd309;
    @(negedge clk);
    n_cmp++; if (draw_terrain !== 1'b0) begin n_mis++; $display("FAIL draw_309: got %b expected 0", draw_terrain); end
    draw_y = 9'd310;
    #1;
    n_cmp++; if (draw_terrain !== 1'b1) begin n_mis++; $display("FAIL draw_310: got %b expected 1", draw_terrain); end
    draw_y = 9'd0;
    $display("test_draw: col 5 boundary at row 310");
  endtask

`ifdef TERRAIN_CARVE_EN
  task automatic test_carve();
    int n;
    logic [8:0] h;
    int crater[11] = '{310, 320, 321, 322, 323, 324, 323, 322, 321, 320, 310};
    carve_x = 10'd100; carve_y = 9'd320; carve_r = 6'd4; carve_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (carve_ack !== 1'b1) begin n_mis++; $display("FAIL crater_ack: got %b expected 1", carve_ack); end
    carve_req = 1'b0;
    wait_idle(n);
    n_cmp++; if (n != 18) begin n_mis++; $display("FAIL crater_cycles: got %0d expected 18", n); end
    for (int c = 95; c <= 105; c++) begin
      read_col(c, h);
      n_cmp++;
      if (h !== 9'(crater[c-95])) begin n_mis++; $display("FAIL crater_col%0d: got %0d expected %0d", c, h, crater[c-95]); end
    end
    // Shallower crater over the same spot must not raise the ground.
    carve_y = 9'd300; carve_req = 1'b1;
    @(negedge clk);
    carve_req = 1'b0;
    wait_idle(n);
    for (int c = 96; c <= 104; c++) begin
      read_col(c, h);
      n_cmp++;
      if (h !== 9'(crater[c-95])) begin n_mis++; $display("FAIL norise_col%0d: got %0d expected %0d", c, h, crater[c-95]); end
    end
    $display("test_carve: crater at 100 took %0d cycles", 18);
  endtask

  task automatic test_edge_clip();
    int n;
    logic [8:0] h;
    int clip[14] = '{478, 479, 479, 479, 478, 477, 476, 475, 474, 473, 472, 471, 470, 310};
    carve_x = 10'd2; carve_y = 9'd470; carve_r = 6'd10; carve_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (carve_ack !== 1'b1) begin n_mis++; $display("FAIL clip_ack: got %b expected 1", carve_ack); end
    carve_req = 1'b0;
    wait_idle(n);
    n_cmp++; if (n != 26) begin n_mis++; $display("FAIL clip_cycles: got %0d expected 26", n); end
    for (int c = 0; c <= 13; c++) begin
      read_col(c, h);
      n_cmp++;
      if (h !== 9'(clip[c])) begin n_mis++; $display("FAIL clip_col%0d: got %0d expected %0d", c, h, clip[c]); end
    end
    read_col(639, h);
    n_cmp++; if (h !== 9'd310) begin n_mis++; $display("FAIL clip_col639: got %0d expected 310", h); end
    $display("test_edge_clip: columns 0..12 carved in %0d cycles", n);
  endtask
`else
  task automatic test_carve_ignored();
    logic [8:0] h;
    carve_x = 10'd100; carve_y = 9'd320; carve_r = 6'd4; carve_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++; if (carve_ack !== 1'b0) begin n_mis++; $display("FAIL ignored_ack: got %b expected 0", carve_ack); end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL ignored_busy: got %b expected 0", busy); end
    end
    carve_req = 1'b0;
    for (int c = 95; c <= 105; c++) begin
      read_col(c, h);
      n_cmp++;
      if (h !== 9'd310) begin n_mis++; $display("FAIL ignored_col%0d: got %0d expected 310", c, h); end
    end
    $display("test_carve_ignored: carve inputs had no effect");
  endtask
`endif

  task automatic test_collision();
    int n;
    logic [8:0] h;
    int col_exp[3];
    mode = 2'b00;
    carve_x = 10'd300; carve_y = 9'd400; carve_r = 6'd0; carve_req = 1'b1;
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL coll_busy: got %b expected 1", busy); end
    n_cmp++; if (carve_ack !== 1'b0) begin n_mis++; $display("FAIL coll_early_ack: got %b expected 0", carve_ack); end
    wait_idle(n);
    n_cmp++; if (n != 640) begin n_mis++; $display("FAIL coll_gen_cycles: got %0d expected 640", n); end
    n_cmp++; if (gen_done !== 1'b1) begin n_mis++; $display("FAIL coll_gen_done: got %b expected 1", gen_done); end
    n_cmp++; if (carve_ack !== 1'b0) begin n_mis++; $display("FAIL coll_ack_with_done: got %b expected 0", carve_ack); end
    @(negedge clk);
`ifdef TERRAIN_CARVE_EN
    n_cmp++; if (carve_ack !== 1'b1) begin n_mis++; $display("FAIL coll_ack: got %b expected 1", carve_ack); end
    carve_req = 1'b0;
    wait_idle(n);
    n_cmp++; if (n != 2) begin n_mis++; $display("FAIL r0_cycles: got %0d expected 2", n); end
    col_exp = '{310, 400, 310};
`else
    n_cmp++; if (carve_ack !== 1'b0) begin n_mis++; $display("FAIL coll_ack: got %b expected 0", carve_ack); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL coll_idle: got %b expected 0", busy); end
    carve_req = 1'b0;
    col_exp = '{310, 310, 310};
`endif
    for (int c = 299; c <= 301; c++) begin
      read_col(c, h);
      n_cmp++;
      if (h !== 9'(col_exp[c-299])) begin n_mis++; $display("FAIL r0_col%0d: got %0d expected %0d", c, h, col_exp[c-299]); end
    end
    $display("test_collision: GEN ran first, %0d cycles", 640);
  endtask

  task automatic test_gentle();
    int n;
    logic [8:0] h;
    int hand[4] = '{310, 310, 309, 308};
    mode = 2'b01;
    seed = 16'hACE1;
    pulse_start();
    wait_idle(n);
    n_cmp++; if (n != 640) begin n_mis++; $display("FAIL gentle_cycles: got %0d expected 640", n); end
    for (int c = 0; c < 4; c++) begin
      read_col(c, h);
      n_cmp++;
      if (h !== 9'(hand[c])) begin n_mis++; $display("FAIL gentle_hand_col%0d: got %0d expected %0d", c, h, hand[c]); end
    end
    rd_col = 10'd0;
    @(negedge clk);
    rd_col = 10'd3;
    #1;
    n_cmp++; if (rd_height !== 9'd310) begin n_mis++; $display("FAIL read_latency_stale: got %0d expected 310", rd_height); end
    @(negedge clk);
    n_cmp++; if (rd_height !== 9'd308) begin n_mis++; $display("FAIL read_latency_new: got %0d expected 308", rd_height); end
    gen_model(16'hACE1, 2'b01);
    for (int c = 0; c < 640; c++) begin
      read_col(c, h);
      n_cmp++;
      if (h !== 9'(exp_h[c])) begin n_mis++; $display("FAIL gentle_col%0d: got %0d expected %0d", c, h, exp_h[c]); end
    end
    $display("test_gentle: generated in %0d cycles", n);
  endtask

  task automatic test_mid_reset();
    int n;
    logic [8:0] h;
    logic ack_seen;
`ifdef TERRAIN_CARVE_EN
    carve_x = 10'd320; carve_y = 9'd470; carve_r = 6'd20; carve_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (carve_ack !== 1'b1) begin n_mis++; $display("FAIL mid_carve_ack: got %b expected 1", carve_ack); end
    carve_req = 1'b0;
    repeat (10) @(negedge clk);
`else
    mode = 2'b10;
    seed = 16'h1234;
    pulse_start();
    repeat (100) @(negedge clk);
`endif
    mode = 2'b10;
    seed = 16'h0000;
    rd_col = 10'd3;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL mid_reset_busy: got %b expected 1", busy); end
    n_cmp++; if (gen_done !== 1'b0) begin n_mis++; $display("FAIL mid_reset_done: got %b expected 0", gen_done); end
    n_cmp++; if (carve_ack !== 1'b0) begin n_mis++; $display("FAIL mid_reset_ack: got %b expected 0", carve_ack); end
    n_cmp++; if (rd_height !== 9'd0) begin n_mis++; $display("FAIL mid_reset_rd_height: got %0d expected 0", rd_height); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    ack_seen = 1'b0;
    while (busy === 1'b1 && n < 3000) begin
      if (carve_ack === 1'b1) ack_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n != 640) begin n_mis++; $display("FAIL rerun_cycles: got %0d expected 640", n); end
    n_cmp++; if (ack_seen !== 1'b0) begin n_mis++; $display("FAIL rerun_ack: got %b expected 0", ack_seen); end
    gen_model(16'hACE1, 2'b10);
    for (int c = 0; c < 640; c++) begin
      read_col(c, h);
      n_cmp++;
      if (h !== 9'(exp_h[c])) begin n_mis++; $display("FAIL rugged_col%0d: got %0d expected %0d", c, h, exp_h[c]); end
      n_cmp++;
      if (h < 9'd64 || h > 9'd479) begin n_mis++; $display("FAIL rugged_range_col%0d: got %0d expected 64..479", c, h); end
    end
    $display("test_mid_reset: rugged seed 0 regenerated in %0d cycles", n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_flat_readback();
    test_draw();
`ifdef TERRAIN_CARVE_EN
    test_carve();
    test_edge_clip();
`else
    test_carve_ignored();
`endif
    test_collision();
    test_gentle();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
